hazard_ctrl: RTL
================

# hazard_ctrl

Stall/flush controller for the 5-stage MIPS pipeline: the control end of the ID/EX pipeline register. It reads the ID/EX register outputs (MemRead, RegWrite, destination) and the IF/ID instruction fields, detects load-use hazards, applies MEM-stage branch/jump redirects and data-memory wait states, and drives the write enables and bubble/flush inputs of PC, IF/ID, ID/EX and EX/MEM. A small FSM masks false re-detection in the cycle after a stall or redirect. Optional performance counters are included.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- ifid_rs  in  5  rs field (instru[25:21]) of IF/ID
- ifid_rt  in  5  rt field (instru[20:16]) of IF/ID
- ifid_uses_rt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
- idex_MemRead  in  1  ID/EX MemRead output
- idex_rt  in  5  rt field of ID/EX instru
- mem_redirect  in  1  taken branch/bne or jump resolved in MEM
- mem_busy  in  1  data memory wait request
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- idex_write  out  1  ID/EX load enable
- exmem_write  out  1  EX/MEM load enable
- pc_src  out  1  1 selects MEM-stage target
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  zero all ID/EX control fields
- exmem_flush  out  1  zero EX/MEM control fields
- state  out  2  FSM state for debug
- stall_cnt, flush_cnt, busy_cnt  out  CNT_W  perf counters (macro only)

## Operation
- Load-use hit (lu): idex_MemRead && idex_rt != 0 && (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt)).
- FSM states: RUN=0, STALL=1, FLUSH=2; encoding 3 is unreachable and returns to RUN.
- Output priority, evaluated combinationally every cycle: rst > mem_busy > mem_redirect > lu (in RUN only) > normal.
- rst: all write enables 0, pc_src 0, all flushes/bubble 1; state <= RUN, counters <= 0.
- mem_busy: all four write enables 0, no flush, pc_src 0; state holds. Redirect and lu are both ignored until busy drops.
- mem_redirect: pc_write=1, pc_src=1, ifid_flush=1, idex_bubble=1, exmem_flush=1; the other enables are 1; state <= FLUSH.
- lu in RUN: pc_write=0, ifid_write=0, idex_bubble=1, exmem_write=1; state <= STALL.
- Normal: all enables 1, no flush, pc_src 0; state <= RUN.
- STALL and FLUSH last exactly one non-busy cycle. In both, lu is masked: ID/EX holds a bubble after a stall, and IF/ID holds a NOP after a flush. The next state is RUN unless a redirect occurs, which goes to FLUSH.
- ID/EX fields other than control (nextPc, ReadData, instru) are don't-care while bubbled.

## Timing
- Hazard outputs are combinational from inputs and the current state in the same cycle. State and counters update on the rising clk edge.
- Load-use costs exactly 1 bubble cycle. Redirect costs 3 squashed instructions, in IF/ID, ID/EX and EX/MEM.
- Redirect and lu in the same cycle: redirect wins, state becomes FLUSH, and no stall is counted.
- Reset mid-stall or mid-flush: the next cycle is RUN with counters at 0.
- mem_busy during STALL or FLUSH: state holds, and the masking cycle is consumed only once busy deasserts.

## Configuration
- HAZARD_PERF_EN defined: the three counters exist. stall_cnt increments on each lu stall cycle, flush_cnt on each redirect cycle, and busy_cnt on each mem_busy cycle. All counters wrap modulo 2^CNT_W and are cleared by rst. Counters do not increment while rst is high.
- HAZARD_PERF_EN undefined: the counter ports and logic are absent. Hazard behaviour is unchanged.

## Structure
- Shared package: FSM state constants (RUN/STALL/FLUSH), the register-number width (5), and the NOP encoding 32'h0000_0000 used by the IF/ID flush.
- One natural sub-module: hazard_perf_cnt, containing the three counters, instantiated only under HAZARD_PERF_EN.

## Test plan
- lw $t0 in ID/EX (idex_MemRead=1, idex_rt=8), add $t1,$t0,$t2 in IF/ID (rs=8) -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; state goes RUN→STALL→RUN; stall_cnt=1.
- Same case with idex_rt=0, or with rt match and ifid_uses_rt=0 -> no stall; all enables 1.
- mem_redirect=1 -> pc_src=1 and all three flushes asserted that cycle; state=FLUSH; flush_cnt=1. A lu pattern held in the next cycle causes no stall.
- mem_redirect and lu asserted together -> redirect outputs only; stall_cnt stays 0.
- mem_busy held for 3 cycles during STALL -> all enables 0 for those 3 cycles; state stays STALL; busy_cnt=3. Returns to RUN one cycle after busy drops.
- rst asserted in FLUSH -> the next cycle has state=RUN and counters at 0. During rst, the enables are 0 and the flushes are 1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: FSM states, register-number width and NOP encoding for hazard_ctrl
package hazard_ctrl_pkg;
    localparam int REG_W = 5;
    localparam logic [31:0] NOP = 32'h0000_0000;
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: wrapping stall, flush and busy event counters, cleared by rst
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_ev,
    input  logic             flush_ev,
    input  logic             busy_ev,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] busy_cnt
);
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            busy_cnt  <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(stall_ev);
            flush_cnt <= flush_cnt + CNT_W'(flush_ev);
            busy_cnt  <= busy_cnt + CNT_W'(busy_ev);
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, MEM redirect flush and busy hold control; HAZARD_PERF_EN adds perf counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_MemRead,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             mem_redirect,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             pc_src,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [1:0]       state
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] busy_cnt
`endif
);
    state_t st;
    logic   lu, stall, go, redir;
    assign lu = idex_MemRead && idex_rt != '0 &&
                (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
    // lu is masked in STALL/FLUSH: ID/EX holds a bubble or IF/ID holds a NOP
    assign stall = st == RUN && lu;
    assign go    = !rst && !mem_busy;
    assign redir = go && mem_redirect;
    assign pc_write    = go && (mem_redirect || !stall);
    assign ifid_write  = pc_write;
    assign idex_write  = go;
    assign exmem_write = go;
    assign pc_src      = redir;
    assign ifid_flush  = rst || redir;
    assign idex_bubble = rst || (go && (mem_redirect || stall));
    assign exmem_flush = rst || redir;
    assign state       = st;
    always_ff @(posedge clk) begin
        if (rst) st <= RUN;
        else if (mem_busy) st <= st;
        else if (mem_redirect) st <= FLUSH;
        else if (stall) st <= STALL;
        else st <= RUN;
    end
`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .clk      (clk),
        .rst      (rst),
        .stall_ev (go && !mem_redirect && stall),
        .flush_ev (redir),
        .busy_ev  (!rst && mem_busy),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
        .busy_cnt (busy_cnt)
    );
`endif
endmodule
